uart_cmd_assembler: RTL and testbench
=====================================

# uart_cmd_assembler

Sits directly downstream of the UART receive frame FSM and deserializer, ahead of the APB master. Consumes validated bytes one per `rx_valid` pulse and assembles command frames (opcode, address, optional write data). Each complete, error-free frame is presented as a single read or write request over a valid/ready handshake. Malformed, stalled and overrun frames are dropped and reported on a one-cycle error strobe.

## Interface
- `ADDR_BYTES`, default 2: address bytes per frame; `req_addr` width is 8*ADDR_BYTES.
- `DATA_BYTES`, default 4: write-data bytes per write frame; `req_wdata` width is 8*DATA_BYTES.
- `TIMEOUT_CYC`, default 1024: maximum idle clocks allowed between bytes inside a frame.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte; valid only while `rx_valid` is high.
- `rx_valid` in 1: one-cycle strobe, one byte per pulse.
- `req_valid` out 1: request pending.
- `req_ready` in 1: downstream APB master accepts the request.
- `req_write` out 1: 1 = write, 0 = read.
- `req_addr` out 8*ADDR_BYTES: request address.
- `req_wdata` out 8*DATA_BYTES: write data; zero for reads.
- `err_valid` out 1: one-cycle error strobe.
- `err_code` out 3: error cause; meaningful only while `err_valid` is high.
- `busy` out 1: high in every state except IDLE.

## Operation
- Frame format: opcode, then ADDR_BYTES address bytes MSB first, then, for writes only, DATA_BYTES data bytes MSB first.
  - Opcode 8'hA5 is write; 8'h5A is read.
- States:
  - IDLE: on `rx_valid`, a valid opcode latches `req_write`, clears the address and data registers, and moves to ADDR. Any other opcode fires `err_code`=1 (BAD_OPCODE) and stays in IDLE.
  - ADDR: shifts in address bytes. After the last one, a write moves to DATA; a read moves to CSUM if enabled, else to ISSUE.
  - DATA: shifts in data bytes. After the last one, moves to CSUM if enabled, else to ISSUE.
  - CSUM: the checksum byte is compared (see Configuration). A match moves to ISSUE; a mismatch fires `err_code`=3 (CHECKSUM) and returns to IDLE.
  - ISSUE: holds `req_valid` until `req_ready` is sampled high, then returns to IDLE.
- Byte counter: reloaded on every state entry. The last byte of a state is identified as count == N-1.
- Timeout applies in ADDR, DATA and CSUM only:
  - The idle counter clears on each `rx_valid`.
  - Reaching TIMEOUT_CYC consecutive idle cycles fires `err_code`=2 (TIMEOUT), returns to IDLE and discards the partial frame.
  - If `rx_valid` arrives on the expiry cycle, the byte wins and no timeout is reported.
- ISSUE overrun: `rx_valid` while `req_ready` is low discards the byte and fires `err_code`=4 (OVERRUN); the request is unaffected.
- ISSUE handshake: on the handshake cycle, a coincident `rx_valid` byte is processed as an IDLE opcode in that same cycle.
- Reset mid-frame: all state is lost and no error is reported.

## Timing
- Reset values: `req_valid`=0, `req_write`=0, `req_addr`=0, `req_wdata`=0, `err_valid`=0, `err_code`=0, `busy`=0; state is IDLE.
- All outputs are registered.
- `req_valid` rises one cycle after the `rx_valid` of the final byte.
- `req_addr`, `req_wdata` and `req_write` are stable from `req_valid` rising until the handshake.
- `req_valid` falls the cycle after `req_ready` is sampled high.
- `err_valid` is high for exactly one cycle, in the cycle after the offending event.
- Throughput: one byte per cycle is accepted back-to-back, with no bubbles.

## Configuration
- `UART_CMD_CHECKSUM_EN` defined:
  - Every frame carries one trailing byte equal to the XOR of all preceding frame bytes, opcode included.
  - A running XOR register is cleared in IDLE.
  - CSUM state exists.
- Not defined:
  - No CSUM state, no XOR register.
  - `err_code`=3 is never produced.
  - Frames are one byte shorter.

## Structure
- Shared package `uart_apb_pkg` holds:
  - opcode constants `OP_WR`=8'hA5 and `OP_RD`=8'h5A;
  - the state encoding;
  - error-code constants ERR_NONE=0, BAD_OPCODE=1, TIMEOUT=2, CHECKSUM=3, OVERRUN=4.
- One sub-module, `rx_timeout_cnt`:
  - inputs: `clk`, `rst`, `enable`, `clear`;
  - output: `expired`;
  - counter width is clog2(TIMEOUT_CYC+1).

## Test plan
- Write frame A5 12 34 DE AD BE EF, back-to-back, `req_ready`=1 → `req_valid` for one cycle with write=1, addr=16'h1234, wdata=32'hDEADBEEF, one cycle after the last byte.
- Read frame 5A 00 40, `req_ready` held low for 5 cycles → request held stable for the 5 cycles with write=0, addr=16'h0040, wdata=0. A byte during the stall → `err_code`=4; the request is still issued.
- Opcode 8'h77 → `err_valid` with code 1, `busy`=0, no request; a following valid frame completes normally.
- A5 12 then 1024 idle cycles → code 2 and return to IDLE. The same gap of 1023 cycles → no error.
- With UART_CMD_CHECKSUM_EN: 5A 00 40 1A → request issued; 5A 00 40 1B → code 3, no request.
- Reset asserted after A5 12 34 → all outputs 0; next frame 5A 00 01 → addr=16'h0001 with no stale data.

Source files
------------

// File: rtl/uart_cmd_assembler_pkg.sv
// Shared opcode, FSM state and error-code definitions for the UART command assembler.
// UART_CMD_CHECKSUM_EN adds the CSUM state.
package uart_apb_pkg;

    localparam logic [7:0] OP_WR = 8'hA5;
    localparam logic [7:0] OP_RD = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
`ifdef UART_CMD_CHECKSUM_EN
        S_CSUM  = 3'd3,
`endif
        S_ISSUE = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        BAD_OPCODE = 3'd1,
        TIMEOUT    = 3'd2,
        CHECKSUM   = 3'd3,
        OVERRUN    = 3'd4
    } err_e;

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Byte-in / request-out / error-strobe bundle for the UART command assembler.
// master = the assembler, slave = the side feeding bytes and consuming requests.
interface uart_cmd_assembler_if #(
    parameter int unsigned ADDR_BYTES = 2,
    parameter int unsigned DATA_BYTES = 4
);
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [8*ADDR_BYTES-1:0] req_addr;
    logic [8*DATA_BYTES-1:0] req_wdata;
    logic                    err_valid;
    logic [2:0]              err_code;
    logic                    busy;

    modport master (
        input  rx_data, rx_valid, req_ready,
        output req_valid, req_write, req_addr, req_wdata, err_valid, err_code, busy
    );

    modport slave (
        output rx_data, rx_valid, req_ready,
        input  req_valid, req_write, req_addr, req_wdata, err_valid, err_code, busy
    );
endinterface

// File: rtl/uart_cmd_assembler_rx_timeout_cnt.sv
// Inter-byte idle counter; expired marks the TIMEOUT_CYC-th consecutive idle cycle
// unless a byte (clear) arrives in that same cycle.
module rx_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (cnt_q != W'(TIMEOUT_CYC)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && !clear && (cnt_q == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles opcode/address/data byte frames from the UART into read/write requests.
// Optional trailing XOR checksum byte enabled by UART_CMD_CHECKSUM_EN.
module uart_cmd_assembler
    import uart_apb_pkg::*;
#(
    parameter int unsigned ADDR_BYTES  = 2,
    parameter int unsigned DATA_BYTES  = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_assembler_if.master bus
);
    localparam int unsigned AW    = 8 * ADDR_BYTES;
    localparam int unsigned DW    = 8 * DATA_BYTES;
    localparam int unsigned MAXB  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int unsigned CNT_W = $clog2(MAXB + 1);
`ifdef UART_CMD_CHECKSUM_EN
    localparam state_e S_TAIL = S_CSUM;
`else
    localparam state_e S_TAIL = S_ISSUE;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             req_valid_q, req_valid_d;
    logic             busy_q, busy_d;
    logic             err_valid_q, err_valid_d;
    err_e             err_code_q, err_code_d;
    logic             take_op;
    logic             tmo_en;
    logic             expired;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]       xor_q, xor_d;
`endif

    always_comb begin
        tmo_en = (state_q == S_ADDR) || (state_q == S_DATA);
`ifdef UART_CMD_CHECKSUM_EN
        if (state_q == S_CSUM) tmo_en = 1'b1;
`endif
    end

    rx_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .enable  (tmo_en),
        .clear   (bus.rx_valid),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        take_op     = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        xor_d       = xor_q;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef UART_CMD_CHECKSUM_EN
                xor_d = '0;
`endif
                take_op = bus.rx_valid;
            end
            S_ADDR: begin
                if (bus.rx_valid) begin
                    addr_d = (addr_q << 8) | AW'(bus.rx_data);
`ifdef UART_CMD_CHECKSUM_EN
                    xor_d = xor_q ^ bus.rx_data;
`endif
                    if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = write_q ? S_DATA : S_TAIL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (expired) begin
                    err_valid_d = 1'b1;
                    err_code_d  = TIMEOUT;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    wdata_d = (wdata_q << 8) | DW'(bus.rx_data);
`ifdef UART_CMD_CHECKSUM_EN
                    xor_d = xor_q ^ bus.rx_data;
`endif
                    if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_TAIL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (expired) begin
                    err_valid_d = 1'b1;
                    err_code_d  = TIMEOUT;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CSUM: begin
                if (bus.rx_valid) begin
                    cnt_d = '0;
                    if (bus.rx_data == xor_q) begin
                        state_d = S_ISSUE;
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = CHECKSUM;
                        state_d     = S_IDLE;
                    end
                end else if (expired) begin
                    err_valid_d = 1'b1;
                    err_code_d  = TIMEOUT;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
            end
`endif
            S_ISSUE: begin
                // A byte on the handshake cycle is already the next frame's opcode.
                if (bus.req_ready) begin
                    state_d = S_IDLE;
                    take_op = bus.rx_valid;
                end else if (bus.rx_valid) begin
                    err_valid_d = 1'b1;
                    err_code_d  = OVERRUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (take_op) begin
            if ((bus.rx_data == OP_WR) || (bus.rx_data == OP_RD)) begin
                write_d = (bus.rx_data == OP_WR);
                addr_d  = '0;
                wdata_d = '0;
                cnt_d   = '0;
                state_d = S_ADDR;
`ifdef UART_CMD_CHECKSUM_EN
                xor_d   = bus.rx_data;
`endif
            end else begin
                err_valid_d = 1'b1;
                err_code_d  = BAD_OPCODE;
                state_d     = S_IDLE;
            end
        end

        req_valid_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
`ifdef UART_CMD_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
`ifdef UART_CMD_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign bus.req_valid = req_valid_q;
    assign bus.req_write = write_q;
    assign bus.req_addr  = addr_q;
    assign bus.req_wdata = wdata_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler; checksum frames used when UART_CMD_CHECKSUM_EN is defined.
module tb_uart_cmd_assembler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    logic [7:0] csum = 8'h00;
    logic       err_seen = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_assembler_if #(.ADDR_BYTES(2), .DATA_BYTES(4)) bus ();

    uart_cmd_assembler #(
        .ADDR_BYTES  (2),
        .DATA_BYTES  (4),
        .TIMEOUT_CYC (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.err_valid === 1'b1) err_seen = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        csum         = csum ^ b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic end_frame();
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(csum);
`endif
        csum = 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_busy",      bus.busy,      0);
        check("rst_err_valid", bus.err_valid, 0);
        check("rst_addr",      bus.req_addr,  0);
        check("rst_wdata",     bus.req_wdata, 0);
        rst = 1'b1;
        tick();

        // back-to-back write frame, ready already high
        csum = 8'h00;
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        end_frame();
        check("wr_valid", bus.req_valid, 1);
        check("wr_write", bus.req_write, 1);
        check("wr_addr",  bus.req_addr,  64'h1234);
        check("wr_wdata", bus.req_wdata, 64'hDEADBEEF);
        check("wr_busy",  bus.busy,      1);
        tick();
        check("wr_valid_drop", bus.req_valid, 0);
        check("wr_busy_drop",  bus.busy,      0);

        // read frame with stalled ready and an overrun byte
        bus.req_ready = 1'b0;
        send_byte(8'h5A); send_byte(8'h00); send_byte(8'h40);
        end_frame();
        check("rd_valid", bus.req_valid, 1);
        check("rd_write", bus.req_write, 0);
        check("rd_addr",  bus.req_addr,  64'h0040);
        check("rd_wdata", bus.req_wdata, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.rx_data  = 8'h33;
                bus.rx_valid = 1'b1;
            end
            tick();
            bus.rx_valid = 1'b0;
            check("stall_valid", bus.req_valid, 1);
            check("stall_addr",  bus.req_addr,  64'h0040);
            check("stall_write", bus.req_write, 0);
            if (i == 2) begin
                check("ovr_err_valid", bus.err_valid, 1);
                check("ovr_err_code",  bus.err_code,  4);
            end
            if (i == 3) check("ovr_err_once", bus.err_valid, 0);
        end
        bus.req_ready = 1'b1;
        tick();
        check("rd_valid_drop", bus.req_valid, 0);

        // bad opcode, then a good frame
        send_byte(8'h77);
        csum = 8'h00;
        check("bad_err_valid", bus.err_valid, 1);
        check("bad_err_code",  bus.err_code,  1);
        check("bad_busy",      bus.busy,      0);
        check("bad_req_valid", bus.req_valid, 0);
        tick();
        check("bad_err_once", bus.err_valid, 0);
        send_byte(8'h5A); send_byte(8'h00); send_byte(8'h40);
        end_frame();
        check("post_bad_valid", bus.req_valid, 1);
        check("post_bad_addr",  bus.req_addr,  64'h0040);
        tick();

        // timeout after exactly 1024 idle cycles
        csum = 8'h00;
        send_byte(8'hA5); send_byte(8'h12);
        csum = 8'h00;
        err_seen = 1'b0;
        repeat (1023) tick();
        check("tmo_early", err_seen, 0);
        check("tmo_busy",  bus.busy, 1);
        tick();
        check("tmo_err_valid", bus.err_valid, 1);
        check("tmo_err_code",  bus.err_code,  2);
        check("tmo_busy_drop", bus.busy,      0);
        check("tmo_no_req",    bus.req_valid, 0);
        tick();

        // byte on the expiry cycle wins
        csum = 8'h00;
        err_seen = 1'b0;
        send_byte(8'hA5); send_byte(8'h12);
        repeat (1023) tick();
        send_byte(8'h34); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        end_frame();
        check("gap_no_err", err_seen,      0);
        check("gap_valid",  bus.req_valid, 1);
        check("gap_addr",   bus.req_addr,  64'h1234);
        check("gap_wdata",  bus.req_wdata, 64'hDEADBEEF);
        tick();

`ifdef UART_CMD_CHECKSUM_EN
        csum = 8'h00;
        send_byte(8'h5A); send_byte(8'h00); send_byte(8'h40); send_byte(8'h1A);
        check("csum_ok_valid", bus.req_valid, 1);
        check("csum_ok_addr",  bus.req_addr,  64'h0040);
        tick();
        send_byte(8'h5A); send_byte(8'h00); send_byte(8'h40); send_byte(8'h1B);
        check("csum_bad_err",   bus.err_valid, 1);
        check("csum_bad_code",  bus.err_code,  3);
        check("csum_bad_noreq", bus.req_valid, 0);
        check("csum_bad_busy",  bus.busy,      0);
        tick();
        csum = 8'h00;
`endif

        // opcode arriving on the handshake cycle starts the next frame
        csum = 8'h00;
        err_seen = 1'b0;
        send_byte(8'h5A); send_byte(8'h00); send_byte(8'h40);
        end_frame();
        check("hs_first_valid", bus.req_valid, 1);
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        end_frame();
        check("hs_no_err", err_seen,      0);
        check("hs_valid",  bus.req_valid, 1);
        check("hs_write",  bus.req_write, 1);
        check("hs_addr",   bus.req_addr,  64'h1234);
        check("hs_wdata",  bus.req_wdata, 64'hDEADBEEF);
        tick();

        // asynchronous reset mid-frame
        csum = 8'h00;
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_write", bus.req_write, 0);
        check("mid_rst_addr",  bus.req_addr,  0);
        check("mid_rst_busy",  bus.busy,      0);
        check("mid_rst_valid", bus.req_valid, 0);
        check("mid_rst_err",   bus.err_valid, 0);
        check("mid_rst_code",  bus.err_code,  0);
        check("mid_rst_wdata", bus.req_wdata, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        csum = 8'h00;
        err_seen = 1'b0;
        send_byte(8'h5A); send_byte(8'h00); send_byte(8'h01);
        end_frame();
        check("post_rst_valid", bus.req_valid, 1);
        check("post_rst_write", bus.req_write, 0);
        check("post_rst_addr",  bus.req_addr,  64'h0001);
        check("post_rst_wdata", bus.req_wdata, 0);
        check("post_rst_noerr", err_seen,      0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
